rps_n: RTL and testbench

RPS_N -- requirements
Module: rps_n

---
 rtl/rps_pkg.sv | 14 +
 rtl/ps_rot.sv | 30 +++
 rtl/rps_n.sv | 90 +++++++++
 tb/tb_rps_n.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared types and parameter limits for the rotating-priority arbiter.
package rps_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int N_MIN        = 2;
    localparam int N_MAX        = 32;
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 255;

endpackage

// File: rtl/ps_rot.sv
// Rotated priority search: first set request scanning ptr, ptr-1, ..., wrapping.
module ps_rot #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    // N is a power of two, so W-bit subtraction wraps around the ring for free
    logic [N-1:0][W-1:0] cand;

    for (genvar k = 0; k < N; k++) begin : g_cand
        assign cand[k] = ptr_i - W'(k);
    end

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && req_i[cand[k]]) begin
                found_o = 1'b1;
                idx_o   = cand[k];
            end
        end
    end

endmodule

// File: rtl/rps_n.sv
// N-way rotating-priority arbiter with optional grant locking and a hold limit.
module rps_n
    import rps_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOCK     = 1,
    parameter int MAX_HOLD = 4,
    localparam int W  = $clog2(N),
    localparam int HW = $clog2(MAX_HOLD + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid,
    output logic         req_up
);

    state_e        state_q, state_d;
    logic [W-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  idx_q, idx_d;

    logic [W-1:0]  win_idx;
    logic          win_found;
    logic          keep;

    ps_rot #(.N(N)) u_ps_rot (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    // A locked grant survives only while its owner still asks and the hold budget remains
    assign keep = (LOCK != 0) && (state_q == GRANT) && req[idx_q]
                  && (hold_q < HW'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = IDLE;
            hold_d  = '0;
            gnt_d   = '0;
            idx_d   = '0;
        end else if (keep) begin
            hold_d = hold_q + 1'b1;
        end else if (win_found) begin
            state_d = GRANT;
            hold_d  = HW'(1);
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
            idx_d   = win_idx;
            ptr_d   = win_idx - 1'b1;
        end else begin
            state_d = IDLE;
            hold_d  = '0;
            gnt_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= W'(N - 1);
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign req_up    = |req;

endmodule

// File: tb/tb_rps_n.sv
// Bench for rps_n: locked and unlocked instances driven from one vector table.
module tb_rps_n;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic       en    = 1'b0;

    logic [3:0] gnt1, gnt0;
    logic [1:0] idx1, idx0;
    logic       vld1, vld0;
    logic       up1, up0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rps_n #(.N(4), .LOCK(1), .MAX_HOLD(4)) dut (
        .clock(clock), .reset(reset), .req(req), .en(en),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1), .req_up(up1)
    );

    rps_n #(.N(4), .LOCK(0), .MAX_HOLD(4)) dut0 (
        .clock(clock), .reset(reset), .req(req), .en(en),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .req_up(up0)
    );

    typedef struct {
        string      name;
        logic       dsel;   // 0 = locked instance, 1 = unlocked instance
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        string      name;
        logic       dsel;
        logic [3:0] gnt;
        logic [1:0] idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    function automatic void add(input string n, input logic d, input logic r,
                                input logic e, input logic [3:0] q, input logic [3:0] g);
        vec_t v;
        v.name = n; v.dsel = d; v.rst = r; v.en = e; v.req = q; v.gnt = g;
        vecs.push_back(v);
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e, p;
        @(negedge clock);
        reset = v.rst; en = v.en; req = v.req;
        e.name = v.name; e.dsel = v.dsel; e.gnt = v.gnt; e.idx = oh2idx(v.gnt);
        sb.push_back(e);
        #1;
        check({v.name, ".req_up"}, 32'(v.dsel ? up0 : up1), 32'(|v.req));
        @(posedge clock);
        #1;
        p = sb.pop_front();
        check({p.name, ".gnt"},   32'(p.dsel ? gnt0 : gnt1), 32'(p.gnt));
        check({p.name, ".idx"},   32'(p.dsel ? idx0 : idx1), 32'(p.idx));
        check({p.name, ".valid"}, 32'(p.dsel ? vld0 : vld1), 32'(|p.gnt));
    endtask

    initial begin
        // Round-robin under constant load with the hold limit
        add("rst",    0, 1, 1, 4'b1111, 4'b0000);
        for (int i = 0; i < 4; i++) add("hold3",  0, 0, 1, 4'b1111, 4'b1000);
        for (int i = 0; i < 4; i++) add("hold2",  0, 0, 1, 4'b1111, 4'b0100);
        add("hand1",  0, 0, 1, 4'b1111, 4'b0010);
        // Early release hands over with no idle cycle
        add("rst",    0, 1, 1, 4'b1111, 4'b0000);
        add("g3a",    0, 0, 1, 4'b1111, 4'b1000);
        add("g3b",    0, 0, 1, 4'b1111, 4'b1000);
        add("drop3",  0, 0, 1, 4'b0111, 4'b0100);
        add("ptr1",   0, 0, 1, 4'b0011, 4'b0010);
        add("to0",    0, 0, 1, 4'b1001, 4'b0001);
        add("wrap3",  0, 0, 1, 4'b1000, 4'b1000);
        add("none",   0, 0, 1, 4'b0000, 4'b0000);
        // Enable drop retains the pointer
        add("rst",    0, 1, 1, 4'b0000, 4'b0000);
        add("g2",     0, 0, 1, 4'b0100, 4'b0100);
        add("en0",    0, 0, 0, 4'b1111, 4'b0000);
        add("en1",    0, 0, 1, 4'b1111, 4'b0010);
        // Reset mid-grant
        add("rst",    0, 1, 1, 4'b0000, 4'b0000);
        add("g2r",    0, 0, 1, 4'b0100, 4'b0100);
        add("rstmid", 0, 1, 1, 4'b0100, 4'b0000);
        add("after",  0, 0, 1, 4'b0001, 4'b0001);
        // Sole requester re-granted at expiry, hold restarts at 1
        add("rst",    0, 1, 1, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) add("solo1",  0, 0, 1, 4'b0010, 4'b0010);
        for (int i = 0; i < 3; i++) add("regr",   0, 0, 1, 4'b0011, 4'b0010);
        add("exp0",   0, 0, 1, 4'b0011, 4'b0001);
        // Unlocked instance rotates every cycle
        add("rst",    1, 1, 1, 4'b1111, 4'b0000);
        add("u3",     1, 0, 1, 4'b1111, 4'b1000);
        add("u2",     1, 0, 1, 4'b1111, 4'b0100);
        add("u1",     1, 0, 1, 4'b1111, 4'b0010);
        add("u0",     1, 0, 1, 4'b1111, 4'b0001);
        add("u3b",    1, 0, 1, 4'b1111, 4'b1000);
        add("uen0",   1, 0, 0, 4'b1111, 4'b0000);
        add("uen1",   1, 0, 1, 4'b1111, 4'b0100);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Random load on both instances: grants stay one-hot and within the request set
        begin
            logic [3:0] rq;
            for (int c = 0; c < 60; c++) begin
                @(negedge clock);
                reset = 1'b0;
                en    = ($urandom_range(0, 7) != 0);
                rq    = 4'($urandom_range(0, 15));
                req   = rq;
                @(posedge clock);
                #1;
                check("rnd.onehot1", 32'($onehot0(gnt1)), 32'd1);
                check("rnd.subset1", 32'(gnt1 & ~rq), 32'd0);
                check("rnd.subset0", 32'(gnt0 & ~rq), 32'd0);
                check("rnd.idx0",    32'(idx0), 32'(oh2idx(gnt0)));
                check("rnd.vld0",    32'(vld0), 32'(|gnt0));
                if (!en) check("rnd.en0", 32'(gnt1 | gnt0), 32'd0);
            end
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
